// File: rtl/mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : mult_seq
// Description : Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
//               One partial-product step per clock, start/fim handshake,
//               zero-operand early-out flagged on zero_op.
//               Optional macro MULT_SEQ_SIGNED_EN selects two's complement
//               operands (sign-magnitude around the unsigned datapath).
// Revision    : 1.0 - initial release
// ============================================================================
module mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mult1,
    input  logic [WIDTH-1:0]     mult2,
    output logic [2*WIDTH-1:0]   produto,
    output logic                 fim,
    output logic                 zero_op,
    output logic                 busy
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CHECK = 2'd1;
    localparam logic [1:0] c_MUL   = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [WIDTH-1:0]     r_mcand;      // multiplicand
    logic [WIDTH-1:0]     r_acc_hi;     // upper half of the running product
    logic [WIDTH-1:0]     r_acc_lo;     // multiplier, shifted out as product bits shift in
    logic [c_CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0]   r_produto;
    logic                 r_fim;
    logic                 r_zero_op;
    logic                 r_busy;

    logic                 w_op_zero;
    logic [WIDTH:0]       w_sum;        // one extra bit keeps the add carry
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_result;
    logic [WIDTH-1:0]     w_op1;
    logic [WIDTH-1:0]     w_op2;

`ifdef MULT_SEQ_SIGNED_EN
    logic                 r_sign;
    logic                 w_sign;

    // Magnitudes of the operands; -2^(WIDTH-1) maps to the unsigned value 2^(WIDTH-1).
    always_comb begin
        w_op1  = mult1[WIDTH-1] ? (~mult1 + WIDTH'(1)) : mult1;
        w_op2  = mult2[WIDTH-1] ? (~mult2 + WIDTH'(1)) : mult2;
        w_sign = mult1[WIDTH-1] ^ mult2[WIDTH-1];
    end

    // Product sign captured with the operands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sign <= 1'b0;
        end else if (r_state == c_IDLE && start) begin
            r_sign <= w_sign;
        end
    end

    // Apply the sign to the unsigned magnitude product; zero stays zero.
    always_comb begin
        w_result = w_prod;
        if (r_sign && (w_prod != '0)) begin
            w_result = ~w_prod + (2*WIDTH)'(1);
        end
    end
`else
    // Unsigned operation: operands and product pass straight through.
    always_comb begin
        w_op1    = mult1;
        w_op2    = mult2;
        w_result = w_prod;
    end
`endif

    // Datapath helpers: zero detect, partial-product add, assembled product.
    always_comb begin
        w_op_zero = (r_mcand == '0) || (r_acc_lo == '0);
        w_sum     = {1'b0, r_acc_hi};
        if (r_acc_lo[0]) begin
            w_sum = {1'b0, r_acc_hi} + {1'b0, r_mcand};
        end
        w_prod    = {r_acc_hi, r_acc_lo};
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_next = c_CHECK;
            c_CHECK: w_state_next = w_op_zero ? c_DONE : c_MUL;
            c_MUL:   if (r_count == c_CNT_ONE) w_state_next = c_DONE;
            c_DONE:  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand capture, shift-add steps and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand   <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_count   <= '0;
            r_produto <= '0;
            r_fim     <= 1'b0;
            r_zero_op <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_busy <= (w_state_next != c_IDLE);
            case (r_state)
                c_IDLE: begin
                    r_fim <= 1'b0;
                    if (start) begin
                        r_mcand  <= w_op1;
                        r_acc_lo <= w_op2;
                    end
                end
                c_CHECK: begin
                    r_acc_hi <= '0;
                    if (w_op_zero) begin
                        r_zero_op <= 1'b1;
                        r_acc_lo  <= '0;
                    end else begin
                        r_zero_op <= 1'b0;
                        r_count   <= c_CNT_INIT;
                    end
                end
                c_MUL: begin
                    r_acc_hi <= w_sum[WIDTH:1];
                    r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
                    r_count  <= r_count - c_CNT_ONE;
                end
                c_DONE: begin
                    r_produto <= w_result;
                    r_fim     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign produto = r_produto;
    assign fim     = r_fim;
    assign zero_op = r_zero_op;
    assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_seq
// Description : Scoreboard bench for mult_seq (WIDTH=8). Stimulus pushes the
//               expected product, zero flag and completion cycle; a monitor
//               pops and compares on every fim pulse.
//               Vectors follow MULT_SEQ_SIGNED_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_seq;

    localparam int WIDTH = 8;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic [WIDTH-1:0]     mult1;
    logic [WIDTH-1:0]     mult2;
    logic [2*WIDTH-1:0]   produto;
    logic                 fim;
    logic                 zero_op;
    logic                 busy;

    typedef struct {
        logic [2*WIDTH-1:0] p;
        logic               z;
        int                 due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    mult_seq #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mult1   (mult1),
        .mult2   (mult2),
        .produto (produto),
        .fim     (fim),
        .zero_op (zero_op),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every fim pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && fim) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fim: got fim=1 with no operation pending (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("produto", 32'(produto), 32'(e.p));
                chk("zero_op", 32'(zero_op), 32'(e.z));
                chk("busy_at_fim", 32'(busy), 32'd0);
                chk("fim_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Present operands with start, let the next edge accept them, queue the expectation.
    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2*WIDTH-1:0] ep, input logic ez,
                         input int lat, input bit push);
        exp_t e;
        start = 1'b1;
        mult1 = a;
        mult2 = b;
        @(posedge clk);
        #1;
        if (push) begin
            e.p   = ep;
            e.z   = ez;
            e.due = cyc + lat;
            sb.push_back(e);
        end
        start = 1'b0;
    endtask

    task automatic wait_fim(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fim) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: got no fim within 40 cycles, expected one", name);
    endtask

    initial begin
        bit got;
        reset = 1'b1;
        start = 1'b0;
        mult1 = '0;
        mult2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_produto", 32'(produto), 32'd0);
        chk("rst_fim", 32'(fim), 32'd0);
        chk("rst_zero_op", 32'(zero_op), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic multiply
        drive(8'd13, 8'd11, 16'h008F, 1'b0, 10, 1'b1);
        chk("busy_running", 32'(busy), 32'd1);
        wait_fim("basic");
        @(negedge clk);

        // Max operands, then back-to-back start in the fim cycle
        drive(8'd255, 8'd255, 16'hFE01, 1'b0, 10, 1'b1);
        wait_fim("max");
        drive(8'd2, 8'd3, 16'h0006, 1'b0, 10, 1'b1);
        wait_fim("b2b");
        @(negedge clk);

        // Zero operand early-out, then a nonzero one clears the flag
        drive(8'd0, 8'd200, 16'h0000, 1'b1, 2, 1'b1);
        wait_fim("zero");
        @(negedge clk);
        drive(8'd1, 8'd1, 16'h0001, 1'b0, 10, 1'b1);
        wait_fim("one");
        @(negedge clk);

        // Busy protection: start held and operands churned while running
        drive(8'd7, 8'd9, 16'h003F, 1'b0, 10, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fim) begin
                start = 1'b0;
                got   = 1'b1;
                break;
            end
            start = 1'b1;
            mult1 = WIDTH'($urandom);
            mult2 = WIDTH'($urandom);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: got no fim within 40 cycles, expected one");
        end
        repeat (15) @(negedge clk);
        chk("busy_after_hold", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of MUL (step 4)
        drive(8'd100, 8'd3, 16'h0000, 1'b0, 10, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_produto", 32'(produto), 32'd0);
        chk("arst_fim", 32'(fim), 32'd0);
        chk("arst_zero_op", 32'(zero_op), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        drive(8'd5, 8'd5, 16'h0019, 1'b0, 10, 1'b1);
        wait_fim("after_reset");
        @(negedge clk);

`ifdef MULT_SEQ_SIGNED_EN
        drive(8'hFD, 8'd5, 16'hFFF1, 1'b0, 10, 1'b1);
        wait_fim("s_neg3x5");
        drive(8'h80, 8'h80, 16'h4000, 1'b0, 10, 1'b1);
        wait_fim("s_min_sq");
        drive(8'h80, 8'h7F, 16'hC080, 1'b0, 10, 1'b1);
        wait_fim("s_min_max");
        drive(8'h00, 8'hFF, 16'h0000, 1'b1, 2, 1'b1);
        wait_fim("s_zero");
`else
        drive(8'hFD, 8'd5, 16'h04F1, 1'b0, 10, 1'b1);
        wait_fim("u_253x5");
        drive(8'h80, 8'h7F, 16'h3F80, 1'b0, 10, 1'b1);
        wait_fim("u_128x127");
        drive(8'hFF, 8'h00, 16'h0000, 1'b1, 2, 1'b1);
        wait_fim("u_zero");
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
